// File: rtl/wall_mask_loader.sv
// wall_mask_loader: streams one mask from BRAM into a shadow register and swaps it live on a frame boundary.
// Loads arriving while busy are dropped. Define WALL_MASK_REVERSE_EN to store the mask bit-reversed (k -> SIZE-1-k).
module wall_mask_loader #(
  parameter int BIT_MASK_WIDTH  = 80,
  parameter int BIT_MASK_HEIGHT = 45,
  parameter int WORD_WIDTH      = 16,
  parameter int NUM_MASKS       = 10,
  parameter int BRAM_LATENCY    = 2,
  parameter int BIT_MASK_SIZE   = BIT_MASK_WIDTH * BIT_MASK_HEIGHT,
  parameter int WORDS_PER_MASK  = (BIT_MASK_SIZE + WORD_WIDTH - 1) / WORD_WIDTH,
  parameter int ADDR_W          = $clog2(NUM_MASKS * WORDS_PER_MASK)
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     load_req_in,
  input  logic [3:0]               bitmask_idx_in,
  input  logic                     frame_boundary_in,
  output logic [ADDR_W-1:0]        bram_addr_out,
  input  logic [WORD_WIDTH-1:0]    bram_data_in,
  output logic [BIT_MASK_SIZE-1:0] wall_bit_mask_out,
  output logic                     busy_out,
  output logic                     mask_valid_out,
  output logic                     swap_pulse_out
);

  localparam int SHADOW_W = WORDS_PER_MASK * WORD_WIDTH;
  localparam int CNT_W    = $clog2(WORDS_PER_MASK + 1);
  localparam logic [CNT_W-1:0] NUM_WORDS = CNT_W'(WORDS_PER_MASK);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORDS_PER_MASK - 1);

  typedef enum logic [1:0] {IDLE, READ, PENDING} state_t;

  state_t                   state_q, state_d;
  logic [ADDR_W-1:0]        base_q, base_d;
  logic [ADDR_W-1:0]        addr_q, addr_d;
  logic [CNT_W-1:0]         iss_q, iss_d;
  logic [CNT_W-1:0]         cap_q, cap_d;
  logic [BRAM_LATENCY-1:0]  vld_q, vld_d;
  logic [SHADOW_W-1:0]      shadow_q;
  logic [BIT_MASK_SIZE-1:0] live_q, live_d, swap_mask;
  logic                     valid_q, valid_d;
  logic                     swap_q, swap_d;
  logic                     issue, capture, do_swap;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    addr_d        = addr_q;
    iss_d         = iss_q;
    cap_d         = cap_q;
    vld_d         = '0;
    valid_d       = valid_q;
    swap_d        = 1'b0;
    do_swap       = 1'b0;
    bram_addr_out = addr_q;
    issue         = (state_q == READ) && (iss_q < NUM_WORDS);
    capture       = (state_q == READ) && vld_q[BRAM_LATENCY-1];

    case (state_q)
      IDLE: begin
        if (load_req_in) begin
          base_d  = (32'(bitmask_idx_in) < NUM_MASKS)
                  ? ADDR_W'(32'(bitmask_idx_in) * WORDS_PER_MASK) : '0;
          iss_d   = '0;
          cap_d   = '0;
          state_d = READ;
        end
      end
      READ: begin
        // Once every address is issued the port keeps showing the last one.
        if (issue) begin
          bram_addr_out = base_q + ADDR_W'(iss_q);
          addr_d        = bram_addr_out;
          iss_d         = iss_q + CNT_W'(1);
        end
        vld_d = BRAM_LATENCY'({vld_q, issue});
        if (capture) begin
          cap_d = cap_q + CNT_W'(1);
          if (cap_q == LAST_WORD) begin
            state_d = PENDING;
          end
        end
      end
      PENDING: begin
        if (frame_boundary_in) begin
          do_swap = 1'b1;
          valid_d = 1'b1;
          swap_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    live_d = do_swap ? swap_mask : live_q;
  end

  always_comb begin
    swap_mask = '0;
`ifdef WALL_MASK_REVERSE_EN
    for (int k = 0; k < BIT_MASK_SIZE; k++) begin
      swap_mask[BIT_MASK_SIZE-1-k] = shadow_q[k];
    end
`else
    swap_mask = shadow_q[BIT_MASK_SIZE-1:0];
`endif
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      base_q  <= '0;
      addr_q  <= '0;
      iss_q   <= '0;
      cap_q   <= '0;
      vld_q   <= '0;
      live_q  <= '0;
      valid_q <= 1'b0;
      swap_q  <= 1'b0;
    end else begin
      base_q  <= base_d;
      addr_q  <= addr_d;
      iss_q   <= iss_d;
      cap_q   <= cap_d;
      vld_q   <= vld_d;
      live_q  <= live_d;
      valid_q <= valid_d;
      swap_q  <= swap_d;
    end
  end

  // Padding bits past BIT_MASK_SIZE in the last word land in the shadow but never reach the output.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      shadow_q <= '0;
    end else if (capture) begin
      shadow_q[32'(cap_q) * WORD_WIDTH +: WORD_WIDTH] <= bram_data_in;
    end
  end

  assign wall_bit_mask_out = live_q;
  assign busy_out          = (state_q != IDLE);
  assign mask_valid_out    = valid_q;
  assign swap_pulse_out    = swap_q;

endmodule

// File: tb/tb_wall_mask_loader.sv
// Bench for wall_mask_loader: BRAM model returns the address as data; scoreboard queues hold expected addresses and masks.
module tb_wall_mask_loader;

  localparam int SIZE = 3600;
  localparam int WPM  = 225;
  localparam int LAT  = 2;
  localparam int AW   = 12;

  logic            clk_in = 1'b0;
  logic            rst_n_in;
  logic            load_req_in;
  logic [3:0]      bitmask_idx_in;
  logic            frame_boundary_in;
  logic [AW-1:0]   bram_addr_out;
  logic [15:0]     bram_data_in;
  logic [SIZE-1:0] wall_bit_mask_out;
  logic            busy_out;
  logic            mask_valid_out;
  logic            swap_pulse_out;

  logic [AW-1:0]   p1 = '0;
  logic [AW-1:0]   p2 = '0;
  logic [SIZE-1:0] live_exp;
  logic            valid_exp;
  int              n_cmp = 0;
  int              n_mis = 0;
  int              addr_sb[$];
  logic [SIZE-1:0] mask_sb[$];

  wall_mask_loader dut (
    .clk_in            (clk_in),
    .rst_n_in          (rst_n_in),
    .load_req_in       (load_req_in),
    .bitmask_idx_in    (bitmask_idx_in),
    .frame_boundary_in (frame_boundary_in),
    .bram_addr_out     (bram_addr_out),
    .bram_data_in      (bram_data_in),
    .wall_bit_mask_out (wall_bit_mask_out),
    .busy_out          (busy_out),
    .mask_valid_out    (mask_valid_out),
    .swap_pulse_out    (swap_pulse_out)
  );

  always #5 clk_in = ~clk_in;

  // Two-cycle BRAM whose contents equal their own address.
  always @(posedge clk_in) begin
    p1 <= bram_addr_out;
    p2 <= p1;
  end
  assign bram_data_in = 16'(p2);

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic logic [SIZE-1:0] exp_mask(input int idx);
    logic [SIZE-1:0] m;
    logic [15:0]     wd;
    m = '0;
    for (int w = 0; w < WPM; w++) begin
      wd = 16'(idx * WPM + w);
      m[w*16 +: 16] = wd;
    end
`ifdef WALL_MASK_REVERSE_EN
    begin
      logic [SIZE-1:0] r;
      for (int k = 0; k < SIZE; k++) r[SIZE-1-k] = m[k];
      m = r;
    end
`endif
    return m;
  endfunction

  task automatic run_load(input int idx, input int exp_idx, input bit extra_req,
                          input bit fb_in_read, input bit fb_with_req,
                          input int pend_wait, input int abort_at);
    logic [SIZE-1:0] m;
    logic [15:0]     first_w, last_w;
    first_w = 16'(exp_idx * WPM);
    last_w  = 16'(exp_idx * WPM + WPM - 1);
    for (int w = 0; w < WPM; w++) addr_sb.push_back(exp_idx * WPM + w);
    mask_sb.push_back(exp_mask(exp_idx));

    load_req_in = 1'b1; bitmask_idx_in = 4'(idx); frame_boundary_in = fb_with_req;
    step();
    load_req_in = 1'b0; frame_boundary_in = 1'b0; bitmask_idx_in = 4'd0;
    chk("busy_rise", busy_out, 1);
    chk("no_swap_at_req", swap_pulse_out, 0);

    for (int c = 0; c < WPM + LAT; c++) begin
      if (c == abort_at) begin
        rst_n_in = 1'b0;
        #1;
        chk("rst_busy", busy_out, 0);
        chk("rst_valid", mask_valid_out, 0);
        chk("rst_swap", swap_pulse_out, 0);
        chk("rst_mask_bits", $countones(wall_bit_mask_out), 0);
        addr_sb.delete();
        mask_sb.delete();
        live_exp  = '0;
        valid_exp = 1'b0;
        step(); step();
        rst_n_in = 1'b1;
        step();
        return;
      end
      if (c < WPM) begin
        if (addr_sb.size() == 0) chk("addr_sb_empty", 1, 0);
        else chk("addr", bram_addr_out, addr_sb.pop_front());
      end
      chk("busy_read", busy_out, 1);
      chk("swap_read", swap_pulse_out, 0);
      chk("mask_hold_read", $countones(wall_bit_mask_out ^ live_exp), 0);
      load_req_in       = extra_req && (c == 10);
      bitmask_idx_in    = 4'd5;
      frame_boundary_in = fb_in_read && ((c % 60 == 5) || (c == WPM + LAT - 1));
      step();
    end
    load_req_in = 1'b0; frame_boundary_in = 1'b0; bitmask_idx_in = 4'd0;

    for (int i = 0; i < pend_wait; i++) begin
      chk("swap_pend", swap_pulse_out, 0);
      chk("mask_hold_pend", $countones(wall_bit_mask_out ^ live_exp), 0);
      step();
    end
    chk("busy_pend", busy_out, 1);
    chk("valid_pend", mask_valid_out, valid_exp);
    chk("addr_hold_pend", bram_addr_out, exp_idx * WPM + WPM - 1);

    frame_boundary_in = 1'b1;
    step();
    frame_boundary_in = 1'b0;
    if (mask_sb.size() == 0) begin
      chk("mask_sb_empty", 1, 0);
    end else begin
      m = mask_sb.pop_front();
      live_exp  = m;
      valid_exp = 1'b1;
      chk("swap_pulse", swap_pulse_out, 1);
      chk("valid_after_swap", mask_valid_out, 1);
      chk("busy_after_swap", busy_out, 0);
      chk("mask_bits_diff", $countones(wall_bit_mask_out ^ m), 0);
`ifdef WALL_MASK_REVERSE_EN
      chk("mask_msb", wall_bit_mask_out[SIZE-1], first_w[0]);
      chk("mask_lsb", wall_bit_mask_out[0], last_w[15]);
`else
      chk("mask_lo_word", wall_bit_mask_out[15:0], first_w);
      chk("mask_hi_word", wall_bit_mask_out[SIZE-1 -: 16], last_w);
`endif
    end
    step();
    chk("swap_one_cycle", swap_pulse_out, 0);
    chk("addr_hold_idle", bram_addr_out, exp_idx * WPM + WPM - 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n_in = 1'b0; load_req_in = 1'b0; bitmask_idx_in = 4'd0; frame_boundary_in = 1'b0;
    live_exp = '0; valid_exp = 1'b0;
    repeat (3) step();
    chk("reset_busy", busy_out, 0);
    chk("reset_mask", $countones(wall_bit_mask_out), 0);
    rst_n_in = 1'b1;
    for (int i = 0; i < 10; i++) begin
      chk("idle_swap", swap_pulse_out, 0);
      step();
    end
    chk("idle_mask", $countones(wall_bit_mask_out), 0);
    chk("idle_busy", busy_out, 0);
    chk("idle_valid", mask_valid_out, 0);
    chk("idle_addr", bram_addr_out, 0);

    // idx 3 with a dropped idx-5 request and frame pulses during READ, including its last cycle.
    run_load(3, 3, 1'b1, 1'b1, 1'b0, 5, -1);
    // idx 10 is out of range and loads mask 0; a frame pulse alongside the request is ignored.
    run_load(10, 0, 1'b0, 1'b0, 1'b1, 0, -1);
    // Highest valid mask.
    run_load(9, 9, 1'b0, 1'b1, 1'b0, 2, -1);
    // idx 12 maps to mask 0; reset lands mid-READ.
    run_load(12, 0, 1'b0, 1'b0, 1'b0, 0, 40);

    for (int i = 0; i < 3; i++) begin
      chk("post_rst_swap", swap_pulse_out, 0);
      step();
    end
    chk("post_rst_busy", busy_out, 0);
    chk("post_rst_valid", mask_valid_out, valid_exp);
    chk("post_rst_mask", $countones(wall_bit_mask_out ^ live_exp), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
